// File: rtl/handshake_pulse_sync_pkg.sv
// ----------------------------------------------------------------------------
// handshake_pulse_sync_pkg
//   Shared constants for the pulse-synchronizer slice.
//   SYNC_STAGES_DEFAULT : flops per synchronizer chain when the top-level
//                         parameter is left at its default (legal 2..4).
// ----------------------------------------------------------------------------
package handshake_pulse_sync_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/handshake_pulse_sync_sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
//   N-stage single-bit synchronizer, asynchronous active-low reset to 0.
//   Used for both directions of the req/ack handshake.
//
//   Parameters
//     STAGES : number of flops in the chain, 2..4
//   Ports
//     clk    in   destination-domain clock
//     rstb   in   destination-domain reset, async active-low
//     d_in   in   signal from the foreign clock domain
//     q_out  out  synchronized copy (last stage of the chain)
// ----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic d_in,
    output logic q_out
);

    // Attributes keep the chain together, close-placed and un-retimed so the
    // first stage has the full period to resolve metastability.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_pulse_sync.sv
// ----------------------------------------------------------------------------
// handshake_pulse_sync
//   Moves a single-cycle event from clk_a to an unrelated clk_b using a
//   four-phase req/ack handshake (req up, ack up, req down, ack down).
//   Only the req-up phase produces pulse_out. Requests arriving while a
//   handshake is in flight are dropped.
//
//   Parameters
//     SYNC_STAGES : flops per synchronizer chain, 2..4
//   Ports
//     clk_a     in   domain-A clock
//     rstb_a    in   domain-A reset, async active-low
//     clk_b     in   domain-B clock
//     rstb_b    in   domain-B reset, async active-low
//     pulse_in  in   domain-A event request, sampled on clk_a
//     pulse_out out  domain-B event, one clk_b cycle per accepted request
// ----------------------------------------------------------------------------
module handshake_pulse_sync
    import handshake_pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_a,
    input  logic rstb_a,
    input  logic clk_b,
    input  logic rstb_b,
    input  logic pulse_in,
    output logic pulse_out
);

    // ---------------- domain A ----------------
    logic req_a_q;
    logic req_a_d;
    logic ack_a_sync;

    // Set only from idle (req low, ack low); hold until the ack arrives;
    // stay low while the ack is still draining. This one expression covers
    // all three: an in-flight ack masks both the set and the hold.
    always_comb begin
        req_a_d = (req_a_q | pulse_in) & ~ack_a_sync;
    end

    always_ff @(posedge clk_a or negedge rstb_a) begin
        if (!rstb_a) begin
            req_a_q <= 1'b0;
        end else begin
            req_a_q <= req_a_d;
        end
    end

    // ---------------- A -> B request ----------------
    logic req_b;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk   (clk_b),
        .rstb  (rstb_b),
        .d_in  (req_a_q),
        .q_out (req_b)
    );

    // ---------------- domain B ----------------
    logic req_b_q;
    logic req_b_d;

    always_comb begin
        req_b_d = req_b;
    end

    always_ff @(posedge clk_b or negedge rstb_b) begin
        if (!rstb_b) begin
            req_b_q <= 1'b0;
        end else begin
            req_b_q <= req_b_d;
        end
    end

    // Both terms come straight from flops on clk_b, so the AND cannot glitch.
    assign pulse_out = req_b & ~req_b_q;

    // ---------------- B -> A acknowledge ----------------
    // The synchronized request itself serves as the acknowledge.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk   (clk_a),
        .rstb  (rstb_a),
        .d_in  (req_b),
        .q_out (ack_a_sync)
    );

endmodule

// File: tb/tb_handshake_pulse_sync.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_handshake_pulse_sync
//   Self-checking bench: scenario table, hand-written reset sequences and a
//   randomized pulse train scored against an event-level acceptance model.
// ----------------------------------------------------------------------------
module tb_handshake_pulse_sync;

    localparam int  T_A_HALF   = 17;
    localparam int  T_B_HALF   = 53;
    localparam int  T_A        = 2 * T_A_HALF;
    localparam int  T_B        = 2 * T_B_HALF;
    // A request is certainly accepted once this long has passed since the
    // previous accepted one (worst-case handshake is well below it) and
    // certainly dropped below the short bound (best-case handshake is above).
    localparam int  ACCEPT_NS  = 1000;
    localparam int  DROP_NS    = 340;
    localparam int  LAT_MAX_NS = 3 * T_B;

    logic clk_a, clk_b, rstb_a, rstb_b, pulse_in, pulse_out;

    handshake_pulse_sync #(.SYNC_STAGES(2)) dut (
        .clk_a     (clk_a),
        .rstb_a    (rstb_a),
        .clk_b     (clk_b),
        .rstb_b    (rstb_b),
        .pulse_in  (pulse_in),
        .pulse_out (pulse_out)
    );

    initial begin clk_a = 1'b0; forever #(T_A_HALF) clk_a = ~clk_a; end
    initial begin clk_b = 1'b0; forever #(T_B_HALF) clk_b = ~clk_b; end

    int    n_pass  = 0;
    int    n_total = 0;
    int    pulse_cnt = 0;
    time   rise_t;
    time   acc_t;
    bit    expect_pending = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- output monitors ----------------
    always @(posedge pulse_out) begin
        pulse_cnt++;
        rise_t = $time;
        if (expect_pending) begin
            check_range("latency_ns", longint'($time - acc_t), 1, LAT_MAX_NS);
            expect_pending = 1'b0;
        end
    end

    always @(negedge pulse_out) begin
        if (rstb_b) check("width_ns", longint'($time - rise_t), T_B);
    end

    int low_run = 0;
    bit seen_pulse = 1'b0;
    bit prev_out = 1'b0;
    always @(negedge clk_b) begin
        if (pulse_out && !prev_out) begin
            if (seen_pulse) check_range("low_gap_cycles", low_run, 3, 1000000);
            seen_pulse = 1'b1;
        end
        if (pulse_out) low_run = 0;
        else           low_run++;
        prev_out = pulse_out;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected end before 1 ms");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // One clk_a-cycle pulse; if the model says it is accepted, arm latency check.
    task automatic send_pulse(input bit accepted);
        @(negedge clk_a);
        pulse_in = 1'b1;
        @(posedge clk_a);
        if (accepted) begin
            acc_t = $time;
            expect_pending = 1'b1;
        end
        @(negedge clk_a);
        pulse_in = 1'b0;
    endtask

    // Acceptance model: decides from elapsed time since last accepted request.
    int since_acc_cyc;

    function automatic bit model_accept(input int gap_cyc);
        since_acc_cyc += gap_cyc;
        if (since_acc_cyc * T_A >= ACCEPT_NS) begin
            since_acc_cyc = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_train(input int n, input int gap_cyc, output int n_acc);
        bit acc;
        n_acc = 0;
        for (int p = 0; p < n; p++) begin
            acc = (p == 0) ? model_accept(1000) : model_accept(gap_cyc);
            if (acc) n_acc++;
            send_pulse(acc);
            if (p != n - 1) repeat (gap_cyc - 1) @(negedge clk_a);
        end
    endtask

    typedef struct {
        string name;
        int    n_pulses;
        int    gap_cyc;
        int    exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c0, n_acc, exp_rand, g;
        bit acc;

        vecs[0] = '{"single",        1,  1, 1};
        vecs[1] = '{"busy_gap2",     2,  2, 1};
        vecs[2] = '{"spaced_1p5us",  2, 45, 2};
        vecs[3] = '{"busy_gap4_x3",  3,  4, 1};
        vecs[4] = '{"spaced_x3",     3, 60, 3};
        vecs[5] = '{"busy_gap6",     2,  6, 1};

        pulse_in = 1'b0;
        rstb_a   = 1'b0;
        rstb_b   = 1'b0;
        since_acc_cyc = 0;

        // ---- reset state ----
        #200;
        check("rst_pulse_out", pulse_out, 0);
        check("rst_req_a",     dut.req_a_q, 0);
        check("rst_req_b",     dut.req_b, 0);
        check("rst_req_b_q",   dut.req_b_q, 0);
        check("rst_ack_a",     dut.ack_a_sync, 0);
        @(negedge clk_a) rstb_a = 1'b1;
        @(negedge clk_b) rstb_b = 1'b1;
        #500;
        check("idle_no_pulse", pulse_cnt, 0);
        #50;

        // ---- table-driven scenarios ----
        foreach (vecs[i]) begin
            c0 = pulse_cnt;
            run_train(vecs[i].n_pulses, vecs[i].gap_cyc, n_acc);
            #2000;
            check({vecs[i].name, "_model"}, n_acc, vecs[i].exp_pulses);
            check({vecs[i].name, "_count"}, pulse_cnt - c0, vecs[i].exp_pulses);
            check({vecs[i].name, "_req_a_idle"}, dut.req_a_q, 0);
        end

        // ---- pulse_in held high for 3 us ----
        c0 = pulse_cnt;
        @(negedge clk_a);
        pulse_in = 1'b1;
        repeat (88) @(negedge clk_a);
        pulse_in = 1'b0;
        #2000;
        check_range("held_high_count", pulse_cnt - c0, 3, 10);
        since_acc_cyc = 1000;

        // ---- rstb_a asserted between req_a rise and pulse_out ----
        c0 = pulse_cnt;
        @(posedge clk_b);
        @(negedge clk_a);
        pulse_in = 1'b1;
        @(posedge clk_a);
        #1;
        pulse_in = 1'b0;
        check("rsta_req_a_set", dut.req_a_q, 1);
        #2;
        rstb_a = 1'b0;
        #1;
        check("rsta_req_a_clr", dut.req_a_q, 0);
        #100;
        @(negedge clk_a) rstb_a = 1'b1;
        #1000;
        check("rsta_no_pulse", pulse_cnt - c0, 0);
        check("rsta_req_b_low", dut.req_b, 0);
        check("rsta_ack_low",  dut.ack_a_sync, 0);
        c0 = pulse_cnt;
        since_acc_cyc = 1000;
        send_pulse(model_accept(1));
        #2000;
        check("rsta_after_one", pulse_cnt - c0, 1);

        // ---- randomized train against the acceptance model ----
        c0 = pulse_cnt;
        exp_rand = 0;
        since_acc_cyc = 1000;
        for (int p = 0; p < 24; p++) begin
            if (p == 0) begin
                g = 1;
            end else if ($urandom_range(0, 1) == 1 &&
                         (since_acc_cyc + 9) * T_A < DROP_NS) begin
                g = $urandom_range(1, 9 - since_acc_cyc > 1 ? 9 - since_acc_cyc : 1);
                repeat (g - 1) @(negedge clk_a);
            end else begin
                g = $urandom_range(35, 60);
                repeat (g - 1) @(negedge clk_a);
            end
            acc = model_accept(p == 0 ? 1000 : g);
            if (acc) exp_rand++;
            send_pulse(acc);
        end
        #2000;
        check("random_count", pulse_cnt - c0, exp_rand);
        check("random_req_a_idle", dut.req_a_q, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/handshake_pulse_sync.md
# handshake_pulse_sync

Carries a single-cycle pulse from clock domain A to an unrelated clock domain B using a four-phase req/ack handshake with multi-flop synchronizers in both directions. It sits on any clock-domain crossing where an event, not data, must arrive in the destination domain exactly once. The two clocks may have any frequency or phase relationship.

## Interface
- SYNC_STAGES, default 2 — flops per synchronizer chain, legal values 2..4.
- clk_a  input  1  domain-A clock; all A-side state on its rising edge.
- rstb_a  input  1  domain-A reset.
- clk_b  input  1  domain-B clock; all B-side state on its rising edge.
- rstb_b  input  1  domain-B reset.
- pulse_in  input  1  domain-A event request, sampled on clk_a.
- pulse_out  output  1  domain-B event, high for exactly one clk_b cycle per accepted request.
- Per clock domain: one clock; reset is asynchronous and active-low (clk_a/rstb_a, clk_b/rstb_b).

## Operation
- A side:
  - req_a flop, reset 0.
  - Idle means req_a=0 and ack_a_sync=0.
  - pulse_in=1 while idle sets req_a at the next clk_a edge.
  - pulse_in=1 while not idle is dropped; no queuing.
- req_a crosses to B through a SYNC_STAGES-flop chain. The last stage is req_b, reset 0.
- B side:
  - req_b_q flop holds the previous req_b, reset 0.
  - pulse_out = req_b & ~req_b_q. Both inputs are flops, so the output is glitch-free.
- req_b is the ack. It returns to A through a SYNC_STAGES-flop chain on clk_a; the last stage is ack_a_sync, reset 0.
- req_a clears on the clk_a edge after ack_a_sync=1.
- The handshake completes when req_b falls, then ack_a_sync falls. A is then idle again.
- Four phases: req↑, ack↑, req↓, ack↓. Only the req↑ phase produces pulse_out.
- pulse_in held high for many cycles is treated as repeated requests. One is accepted per completed handshake.
- Reset:
  - Each reset clears only its own domain's flops, asynchronously. Deassertion is assumed to be synchronized externally to its clock.
  - pulse_out = 0 in reset.
  - rstb_a low mid-handshake: req_a drops. B sees req_b fall without a second pulse and then idles.
  - rstb_b low mid-handshake: ack drops and req_b_q clears. If req_a is still high after rstb_b releases, B emits one more pulse_out. This duplicate is accepted behaviour.

## Timing
- Request accept: pulse_in high at clk_a edge k sets req_a at edge k.
- pulse_out rises SYNC_STAGES clk_b edges after req_a rises, with +1 edge of synchronizer uncertainty. It lasts exactly 1 clk_b cycle.
- ack_a_sync rises SYNC_STAGES clk_a edges after req_b, +1 edge.
- Minimum spacing between accepted requests ≈ 2·(SYNC_STAGES+1)·(T_a + T_b).
- A and B outputs have no combinational path between domains. Synchronizer flops are the only cross-domain receivers.

## Structure
- Shared package: SYNC_STAGES_DEFAULT constant only. No typedefs needed.
- One sub-module, sync_ff: an N-stage synchronizer with async active-low reset to 0. It is instantiated twice, once for req A→B and once for ack B→A, and carries ASYNC_REG/dont-touch attributes.
- Top level holds the req_a set/clear logic and the B-side edge detector.

## Test plan
Clocks: clk_a half-period 17 ns, clk_b half-period 53 ns, SYNC_STAGES=2.
- Both resets low: pulse_out=0 and all flops 0. Release rstb_a on a clk_a edge, then rstb_b on a clk_b edge: pulse_out stays 0 with pulse_in=0.
- Single 1-cycle pulse_in 50 ns after reset: exactly one pulse_out, 106 ns wide, rising within 3 clk_b edges of req_a↑. req_a returns to 0, and the block is idle within ~12 cycles.
- Second pulse_in 2 clk_a cycles after the first (busy): dropped. Exactly one pulse_out in total.
- Two pulses separated by 1.5 µs: exactly two pulse_out, each 1 clk_b cycle.
- pulse_in held high for 3 µs: pulse_out count equals the number of completed handshakes. Pulses are never adjacent, with at least 3 clk_b cycles low between them.
- rstb_a asserted between req_a↑ and pulse_out: no pulse_out. req_b returns to 0, and a subsequent request still yields exactly one pulse.
